// File: rtl/umi_fifo_width_pkg.sv
// Shared UMI command field layout, split-eligible opcodes and packet size helper
// for the width-converting UMI FIFO.
package umi_fifo_width_pkg;

  // Command field positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 5;
  localparam int SIZE_LSB   = 5;
  localparam int SIZE_W     = 3;
  localparam int LEN_LSB    = 8;
  localparam int LEN_W      = 8;
  localparam int EOM_BIT    = 22;

  // Opcodes whose payload may be split across narrower output beats
  localparam logic [OPCODE_W-1:0] UMI_RESP_READ  = 5'h02;
  localparam logic [OPCODE_W-1:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [OPCODE_W-1:0] UMI_REQ_POSTED = 5'h05;

  // Byte count width: (255+1) << 7 = 32768 needs 16 bits, one spare
  localparam int BW = 17;

  // Packet bytes B = (len+1) << size
  function automatic logic [BW-1:0] umi_bytes(input logic [SIZE_W-1:0] size,
                                              input logic [LEN_W-1:0]  len);
    umi_bytes = (BW'(len) + BW'(1)) << size;
  endfunction

endpackage

// File: rtl/umi_width_split.sv
// Combinational chunk generator: given a stored UMI packet and the byte offset
// of the chunk being presented, produce that chunk's cmd, addresses and data,
// and flag whether it is the final chunk of the packet.
module umi_width_split
  import umi_fifo_width_pkg::*;
#(
  parameter int CW  = 32,
  parameter int IAW = 64,
  parameter int IDW = 512,
  parameter int OAW = 64,
  parameter int ODW = 512
) (
  input  logic [CW-1:0]  cmd,
  input  logic [IAW-1:0] dstaddr,
  input  logic [IAW-1:0] srcaddr,
  input  logic [IDW-1:0] data,
  input  logic [BW-1:0]  offset,
  output logic [CW-1:0]  out_cmd,
  output logic [OAW-1:0] out_dstaddr,
  output logic [OAW-1:0] out_srcaddr,
  output logic [ODW-1:0] out_data,
  output logic           last
);

  localparam int C  = ODW / 8;
  localparam int XW = (IDW > ODW) ? IDW : ODW;
  localparam int AW = (IAW > OAW) ? IAW : OAW;

  logic [OPCODE_W-1:0] opcode;
  logic [SIZE_W-1:0]   size;
  logic [LEN_W-1:0]    len;
  logic [BW-1:0]       bytes;
  logic [BW-1:0]       cap;
  logic [BW-1:0]       remain;
  logic [BW-1:0]       off_eff;
  logic                split;
  logic [XW-1:0]       data_x;
  logic [AW-1:0]       dst_x;
  logic [AW-1:0]       src_x;

  // Decide whether the packet splits, then shape the current chunk
  always_comb begin
    opcode  = cmd[OPCODE_LSB +: OPCODE_W];
    size    = cmd[SIZE_LSB +: SIZE_W];
    len     = cmd[LEN_LSB +: LEN_W];
    bytes   = umi_bytes(size, len);
    cap     = BW'(C);
    remain  = bytes - offset;
    split   = ((opcode == UMI_RESP_READ) || (opcode == UMI_REQ_WRITE) ||
               (opcode == UMI_REQ_POSTED)) &&
              (bytes > cap) && ((BW'(1) << size) <= cap);
    out_cmd = cmd;
    last    = 1'b1;
    off_eff = '0;
    if (split) begin
      // offset is always a multiple of C, so remain is a whole number of words
      last    = (remain <= cap);
      off_eff = offset;
      if (last) begin
        out_cmd[LEN_LSB +: LEN_W] = LEN_W'((remain >> size) - BW'(1));
      end else begin
        out_cmd[LEN_LSB +: LEN_W] = LEN_W'((cap >> size) - BW'(1));
        out_cmd[EOM_BIT]          = 1'b0;
      end
    end
    dst_x       = AW'(dstaddr) + AW'(off_eff);
    src_x       = AW'(srcaddr) + AW'(off_eff);
    data_x      = XW'(data) >> {off_eff, 3'b000};
    out_dstaddr = dst_x[OAW-1:0];
    out_srcaddr = src_x[OAW-1:0];
    out_data    = data_x[ODW-1:0];
  end

endmodule

// File: rtl/umi_fifo_width.sv
// Single-clock UMI packet FIFO with IDW -> ODW width conversion. Whole input
// packets are stored; wide data packets leave as several consecutive chunks and
// the entry is released only after its last chunk is accepted.
module umi_fifo_width
  import umi_fifo_width_pkg::*;
#(
  parameter int CW    = 32,
  parameter int IAW   = 64,
  parameter int IDW   = 512,
  parameter int OAW   = 64,
  parameter int ODW   = 512,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           umi_in_valid,
  output logic           umi_in_ready,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [IAW-1:0] umi_in_dstaddr,
  input  logic [IAW-1:0] umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_out_valid,
  input  logic           umi_out_ready,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [OAW-1:0] umi_out_dstaddr,
  output logic [OAW-1:0] umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  output logic           fifo_full,
  output logic           fifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int C  = ODW / 8;

  logic [CW-1:0]  mem_cmd [DEPTH];
  logic [IAW-1:0] mem_dst [DEPTH];
  logic [IAW-1:0] mem_src [DEPTH];
  logic [IDW-1:0] mem_data[DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [BW-1:0]  offset;
  logic           push;
  logic           beat;

  logic [CW-1:0]  s_cmd;
  logic [OAW-1:0] s_dst;
  logic [OAW-1:0] s_src;
  logic [ODW-1:0] s_data;
  logic           s_last;

  // Pointer-derived status; ready is held low while in reset
  always_comb begin
    fifo_empty    = (wr_ptr == rd_ptr);
    fifo_full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    umi_in_ready  = nreset & ~fifo_full;
    umi_out_valid = ~fifo_empty;
    push          = umi_in_valid & umi_in_ready;
    beat          = umi_out_valid & umi_out_ready;
  end

  // Payload storage, written on push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr[AW-1:0]]  <= umi_in_cmd;
      mem_dst[wr_ptr[AW-1:0]]  <= umi_in_dstaddr;
      mem_src[wr_ptr[AW-1:0]]  <= umi_in_srcaddr;
      mem_data[wr_ptr[AW-1:0]] <= umi_in_data;
    end
  end

  // Write pointer advances on each accepted input packet
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Read side walks chunk offsets and pops only after the last chunk
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr <= '0;
      offset <= '0;
    end else if (beat) begin
      if (s_last) begin
        rd_ptr <= rd_ptr + PW'(1);
        offset <= '0;
      end else begin
        offset <= offset + BW'(C);
      end
    end
  end

  umi_width_split #(
    .CW  (CW),
    .IAW (IAW),
    .IDW (IDW),
    .OAW (OAW),
    .ODW (ODW)
  ) u_split (
    .cmd         (mem_cmd[rd_ptr[AW-1:0]]),
    .dstaddr     (mem_dst[rd_ptr[AW-1:0]]),
    .srcaddr     (mem_src[rd_ptr[AW-1:0]]),
    .data        (mem_data[rd_ptr[AW-1:0]]),
    .offset      (offset),
    .out_cmd     (s_cmd),
    .out_dstaddr (s_dst),
    .out_srcaddr (s_src),
    .out_data    (s_data),
    .last        (s_last)
  );

  // Output fields read as zero whenever nothing is presented (including reset)
  always_comb begin
    umi_out_cmd     = umi_out_valid ? s_cmd  : '0;
    umi_out_dstaddr = umi_out_valid ? s_dst  : '0;
    umi_out_srcaddr = umi_out_valid ? s_src  : '0;
    umi_out_data    = umi_out_valid ? s_data : '0;
  end

endmodule

// File: tb/tb_umi_fifo_width.sv
// Directed bench for umi_fifo_width: one 512->512 instance and one 512->256
// instance sharing clock and reset.
module tb_umi_fifo_width;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 512 -> 512
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
  logic [31:0]  a_in_cmd, a_out_cmd;
  logic [63:0]  a_in_dst, a_in_src, a_out_dst, a_out_src;
  logic [511:0] a_in_data, a_out_data;

  // Instance B: 512 -> 256
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
  logic [31:0]  b_in_cmd, b_out_cmd;
  logic [63:0]  b_in_dst, b_in_src, b_out_dst, b_out_src;
  logic [511:0] b_in_data;
  logic [255:0] b_out_data;

  umi_fifo_width #(.CW(32), .IAW(64), .IDW(512), .OAW(64), .ODW(512), .DEPTH(4)) u_dut_a (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (a_in_valid),
    .umi_in_ready    (a_in_ready),
    .umi_in_cmd      (a_in_cmd),
    .umi_in_dstaddr  (a_in_dst),
    .umi_in_srcaddr  (a_in_src),
    .umi_in_data     (a_in_data),
    .umi_out_valid   (a_out_valid),
    .umi_out_ready   (a_out_ready),
    .umi_out_cmd     (a_out_cmd),
    .umi_out_dstaddr (a_out_dst),
    .umi_out_srcaddr (a_out_src),
    .umi_out_data    (a_out_data),
    .fifo_full       (a_full),
    .fifo_empty      (a_empty)
  );

  umi_fifo_width #(.CW(32), .IAW(64), .IDW(512), .OAW(64), .ODW(256), .DEPTH(4)) u_dut_b (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (b_in_valid),
    .umi_in_ready    (b_in_ready),
    .umi_in_cmd      (b_in_cmd),
    .umi_in_dstaddr  (b_in_dst),
    .umi_in_srcaddr  (b_in_src),
    .umi_in_data     (b_in_data),
    .umi_out_valid   (b_out_valid),
    .umi_out_ready   (b_out_ready),
    .umi_out_cmd     (b_out_cmd),
    .umi_out_dstaddr (b_out_dst),
    .umi_out_srcaddr (b_out_src),
    .umi_out_data    (b_out_data),
    .fifo_full       (b_full),
    .fifo_empty      (b_empty)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte i of the pattern is i + seed
  function automatic logic [511:0] pat(input logic [7:0] seed);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = 8'(i) + seed;
    return v;
  endfunction

  // Drive one packet into B; call just after a rising edge, returns just after the push edge
  task automatic push_b(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                        input logic [511:0] dat);
    b_in_cmd   = c;
    b_in_dst   = d;
    b_in_src   = s;
    b_in_data  = dat;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    int idx;
    int seen;

    nreset = 1'b0;
    a_in_valid = 1'b0; a_in_cmd = '0; a_in_dst = '0; a_in_src = '0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_cmd = '0; b_in_dst = '0; b_in_src = '0; b_in_data = '0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 512'(a_out_valid), 512'(0));
    chk("rst_a_empty", 512'(a_empty), 512'(1));
    chk("rst_a_full", 512'(a_full), 512'(0));
    chk("rst_a_in_ready", 512'(a_in_ready), 512'(0));
    chk("rst_b_cmd", 512'(b_out_cmd), 512'(0));
    chk("rst_b_data", 512'(b_out_data), 512'(0));
    @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    chk("a_in_ready_after_rst", 512'(a_in_ready), 512'(1));

    // Equal width: one beat, unchanged, one cycle latency
    d = pat(8'h00);
    @(posedge clk);
    #1;
    a_in_cmd = 32'h0040_3F03; a_in_dst = 64'h1000; a_in_src = 64'h2000; a_in_data = d;
    a_in_valid = 1'b1;
    @(negedge clk);
    chk("t1_pre_valid", 512'(a_out_valid), 512'(0));
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 512'(a_out_valid), 512'(1));
    chk("t1_cmd", 512'(a_out_cmd), 512'(32'h0040_3F03));
    chk("t1_dst", 512'(a_out_dst), 512'(64'h1000));
    chk("t1_src", 512'(a_out_src), 512'(64'h2000));
    chk("t1_data", a_out_data, d);
    @(posedge clk);
    @(negedge clk);
    chk("t1_done_valid", 512'(a_out_valid), 512'(0));
    chk("t1_done_empty", 512'(a_empty), 512'(1));

    // 512 -> 256 write split into two chunks
    d = pat(8'h40);
    @(posedge clk);
    #1 push_b(32'h0040_3F03, 64'h1000, 64'h2000, d);
    @(negedge clk);
    chk("t2_b1_valid", 512'(b_out_valid), 512'(1));
    chk("t2_b1_cmd", 512'(b_out_cmd), 512'(32'h0000_1F03));
    chk("t2_b1_dst", 512'(b_out_dst), 512'(64'h1000));
    chk("t2_b1_src", 512'(b_out_src), 512'(64'h2000));
    chk("t2_b1_data", 512'(b_out_data), 512'(d[255:0]));
    @(posedge clk);
    @(negedge clk);
    chk("t2_b2_valid", 512'(b_out_valid), 512'(1));
    chk("t2_b2_cmd", 512'(b_out_cmd), 512'(32'h0040_1F03));
    chk("t2_b2_dst", 512'(b_out_dst), 512'(64'h1020));
    chk("t2_b2_src", 512'(b_out_src), 512'(64'h2020));
    chk("t2_b2_data", 512'(b_out_data), 512'(d[511:256]));
    @(posedge clk);
    @(negedge clk);
    chk("t2_done_valid", 512'(b_out_valid), 512'(0));
    chk("t2_done_empty", 512'(b_empty), 512'(1));

    // Read request is never split
    d = pat(8'h80);
    @(posedge clk);
    #1 push_b(32'h0040_3F01, 64'h3000, 64'h3100, d);
    @(negedge clk);
    chk("t3_cmd", 512'(b_out_cmd), 512'(32'h0040_3F01));
    chk("t3_dst", 512'(b_out_dst), 512'(64'h3000));
    chk("t3_data", 512'(b_out_data), 512'(d[255:0]));
    @(posedge clk);
    @(negedge clk);
    chk("t3_empty", 512'(b_empty), 512'(1));

    // Fill with the output stalled, then drain in order
    @(posedge clk);
    #1 b_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_b(32'h0000_0001, 64'(k * 256), 64'h0, pat(8'(k)));
    @(negedge clk);
    chk("t4_full", 512'(b_full), 512'(1));
    chk("t4_in_ready", 512'(b_in_ready), 512'(0));
    chk("t4_not_empty", 512'(b_empty), 512'(0));
    @(posedge clk);
    #1 b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_drain_dst", 512'(b_out_dst), 512'(64'(k * 256)));
      @(posedge clk);
    end
    @(negedge clk);
    chk("t4_empty", 512'(b_empty), 512'(1));
    chk("t4_not_full", 512'(b_full), 512'(0));

    // Ready toggling during a two-chunk split
    d = pat(8'h10);
    @(posedge clk);
    #1 b_out_ready = 1'b0;
    push_b(32'h0040_3F03, 64'h4000, 64'h4400, d);
    idx  = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      b_out_ready = (c % 2) == 1;
      @(negedge clk);
      if (idx < 2) begin
        chk("t5_valid", 512'(b_out_valid), 512'(1));
        chk("t5_dst", 512'(b_out_dst), 512'(64'h4000 + 64'(idx * 32)));
        chk("t5_eom", 512'(b_out_cmd[22]), 512'(idx == 1));
        chk("t5_data", 512'(b_out_data), 512'((idx == 1) ? d[511:256] : d[255:0]));
      end else begin
        chk("t5_idle_valid", 512'(b_out_valid), 512'(0));
      end
      if (b_out_valid && b_out_ready) seen++;
      if (b_out_ready && idx < 2) idx++;
      @(posedge clk);
      #1;
    end
    chk("t5_beats", 512'(seen), 512'(2));

    // Reset after the first chunk discards the rest
    push_b(32'h0040_3F03, 64'h5000, 64'h5100, pat(8'h20));
    @(negedge clk);
    chk("t6_b1_dst", 512'(b_out_dst), 512'(64'h5000));
    @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    chk("t6_rst_valid", 512'(b_out_valid), 512'(0));
    chk("t6_rst_empty", 512'(b_empty), 512'(1));
    chk("t6_rst_cmd", 512'(b_out_cmd), 512'(0));
    @(posedge clk);
    #1 nreset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_post_valid", 512'(b_out_valid), 512'(0));
    end
    d = pat(8'h30);
    @(posedge clk);
    #1 push_b(32'h0040_3F03, 64'h6000, 64'h6100, d);
    @(negedge clk);
    chk("t6_new_dst", 512'(b_out_dst), 512'(64'h6000));
    chk("t6_new_cmd", 512'(b_out_cmd), 512'(32'h0000_1F03));
    chk("t6_new_data", 512'(b_out_data), 512'(d[255:0]));
    @(posedge clk);
    @(negedge clk);
    chk("t6_new_dst2", 512'(b_out_dst), 512'(64'h6020));
    @(posedge clk);
    @(negedge clk);
    chk("t6_final_empty", 512'(b_empty), 512'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/umi_fifo_width.md
Name: umi_fifo_width

Overview:
- Single-clock UMI packet FIFO that also converts data width from IDW (input) to ODW (output).
- Data-carrying packets larger than ODW/8 bytes are split into several consecutive output packets, with lengths and addresses adjusted per chunk.
- Sits between a UMI producer and a narrower (or equal-width) UMI consumer inside one clock domain.

Parameters:
- CW, 32: UMI command width.
- IAW, 64: input address width.
- IDW, 512: input data width in bits; power of 2, at least 64.
- OAW, 64: output address width.
- ODW, 512: output data width in bits; power of 2, at least 64.
- DEPTH, 4: FIFO depth in whole input packets; power of 2, at least 2.

Ports:
- clk  in  1  single clock.
- nreset  in  1  asynchronous active-low reset.
- umi_in_valid  in  1  input packet valid.
- umi_in_ready  out  1  input ready; equals !full.
- umi_in_cmd  in  CW  input command.
- umi_in_dstaddr  in  IAW  input destination address.
- umi_in_srcaddr  in  IAW  input source address.
- umi_in_data  in  IDW  input data.
- umi_out_valid  out  1  output valid.
- umi_out_ready  in  1  output ready.
- umi_out_cmd  out  CW  output command.
- umi_out_dstaddr  out  OAW  output destination address.
- umi_out_srcaddr  out  OAW  output source address.
- umi_out_data  out  ODW  output data.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.

Behaviour:
- Reset is asynchronous, active-low. During reset: wr_ptr=rd_ptr=0, split offset=0, umi_out_valid=0, fifo_empty=1, fifo_full=0, umi_in_ready=0 while nreset low. All outputs are 0 in reset.
- Handshakes:
  - Push when umi_in_valid & umi_in_ready.
  - An output beat completes when umi_out_valid & umi_out_ready.
  - umi_out_* must hold stable while valid & !ready.
- Storage is a DEPTH-entry register array of {cmd, dstaddr, srcaddr, data}, with (log2 DEPTH + 1)-bit pointers.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Latency: a packet pushed at edge N is presented at the output after edge N; umi_out_valid is high in cycle N+1 when the FIFO was previously empty. There is no combinational in-to-out path.
- Simultaneous push and pop while full is not allowed, because ready=!full. Simultaneous push and pop otherwise leaves the occupancy unchanged.
- Command fields: opcode=cmd[4:0], size=cmd[7:5], len=cmd[15:8], eom=cmd[22].
  - Packet bytes B = (len+1) << size.
  - Output chunk capacity C = ODW/8.
- Split rule applies to opcodes 0x02 (RESP_READ), 0x03 (REQ_WRITE) and 0x05 (REQ_POSTED) when B > C:
  - Each chunk has len' = (C >> size) - 1, except the last chunk, which carries the remainder.
  - Chunk k has data = input data bytes [k*C, (k+1)*C).
  - dstaddr and srcaddr advance by k*C.
  - eom is cleared on all chunks except the last; the last chunk copies the input eom.
  - All other cmd bits are copied unchanged.
  - The FIFO entry is popped only when the last chunk completes.
- Non-split cases are forwarded unchanged as one beat:
  - B <= C, other opcodes, or (1<<size) > C.
  - Data is truncated to ODW, or zero-extended when ODW > IDW.
- Addresses are zero-extended or truncated from IAW to OAW.
- Reset asserted mid-split aborts the packet; the remaining chunks are discarded.

Decomposition:
- A shared package holds the cmd field offsets (OPCODE, SIZE, LEN, EOM), the opcode constants (0x02, 0x03, 0x05) and a function computing B.
- One natural sub-module: umi_width_split, a combinational chunk generator taking {cmd, addrs, data, offset} and producing {cmd', addrs', data', last}.
- The FIFO storage stays in the top module.

Test Plan:
- IDW=ODW=512: push REQ_WRITE with size=0, len=63, dst=0x1000 -> one output beat, identical cmd/addrs/data, latency 1 cycle.
- IDW=512, ODW=256: push REQ_WRITE with size=0, len=63, dst=0x1000, src=0x2000, eom=1 -> two beats.
  - Beat 1: len=31, dst=0x1000, src=0x2000, eom=0, data=in[255:0].
  - Beat 2: len=31, dst=0x1020, src=0x2020, eom=1, data=in[511:256].
- IDW=512, ODW=256: REQ_READ (0x01) with len=63 -> forwarded unsplit as one beat.
- DEPTH=4, umi_out_ready=0: push 4 packets -> fifo_full=1 and umi_in_ready=0; assert ready -> packets drain in order, then fifo_empty=1.
- Output ready toggling every other cycle during a 2-chunk split -> outputs stable while stalled; no chunk is lost or duplicated.
- nreset pulsed low after the first chunk of a split -> umi_out_valid=0 immediately, FIFO empty, no second chunk after release.
